// File: rtl/vga_fb_scanout.sv
// VGA scan-out reader: 640x480@60 timing, rotated 2x-scaled frame-buffer reads,
// RGB332 -> RGB444 expansion, with hsync/vsync delay-matched to the colour path.
`timescale 1ns/1ps

module vga_fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_W     = 240,
    parameter int FB_H     = 320,
    parameter int ADDR_W   = 17,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              hsync,
    output logic              vsync,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic [9:0]        hc,
    output logic [9:0]        vc,
    output logic              vblank,
    output logic              frame_done
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int L  = RD_LAT + 2;

    localparam logic [9:0] HT_LAST = 10'(HT - 1);
    localparam logic [9:0] VT_LAST = 10'(VT - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] FB_W_L  = 10'(FB_W);
    localparam logic [9:0] FB_H_L  = 10'(FB_H);

    // Stage 0: raster counters
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;

    // Stage A: read request
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    // Delay lines and stage O
    logic [RD_LAT-1:0] act_pipe_q, act_pipe_d;
    logic [L-1:0]      hs_pipe_q, hs_pipe_d;
    logic [L-1:0]      vs_pipe_q, vs_pipe_d;
    logic [3:0]        red_q, red_d;
    logic [3:0]        green_q, green_d;
    logic [3:0]        blue_q, blue_d;

    logic              pix_active;
    logic              in_fb;
    logic              hs_raw;
    logic              vs_raw;
    logic              act_at_data;
    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] xpos;

    always_comb begin
        // NOTE: every _d is given a default before any branch, so no path can infer a latch.
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == HT_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == VT_LAST) ? '0 : vc_q + 10'd1;
        end
    end

    // Screen x walks the buffer's rows; screen y walks its columns right-to-left.
    always_comb begin
        y_ext    = ADDR_W'(hc_q[9:1]);
        row_base = (y_ext << 8) - (y_ext << 4);
        xpos     = ADDR_W'(FB_W - 1) - ADDR_W'(vc_q[9:1]);
        // Guards against a timing/buffer parameter mismatch ever addressing past the buffer.
        in_fb      = ({1'b0, hc_q[9:1]} < FB_H_L) && ({1'b0, vc_q[9:1]} < FB_W_L);
        pix_active = (hc_q < H_ACT) && (vc_q < V_ACT) && in_fb;

        rd_en_d   = pix_active;
        rd_addr_d = pix_active ? (row_base + xpos) : rd_addr_q;
    end

    always_comb begin
        hs_raw = !((hc_q >= HS_BEG) && (hc_q < HS_END));
        vs_raw = !((vc_q >= VS_BEG) && (vc_q < VS_END));

        hs_pipe_d  = L'({hs_pipe_q, hs_raw});
        vs_pipe_d  = L'({vs_pipe_q, vs_raw});
        act_pipe_d = RD_LAT'({act_pipe_q, rd_en_q});
    end

    // The active flag leaves the delay line in the same clock rd_data is valid.
    assign act_at_data = act_pipe_q[RD_LAT-1];

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (act_at_data) begin
            red_d   = {rd_data[7:5], rd_data[7]};
            green_d = {rd_data[4:2], rd_data[4]};
            blue_d  = {rd_data[1:0], rd_data[1:0]};
        end
    end

    // NOTE: the delay lines are reset too, otherwise pre-reset colour or sync could leak out after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc_q       <= '0;
            vc_q       <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            act_pipe_q <= '0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples the previous stage's old value.
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            act_pipe_q <= act_pipe_d;
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign hsync      = hs_pipe_q[L-1];
    assign vsync      = vs_pipe_q[L-1];
    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign hc         = hc_q;
    assign vc         = vc_q;
    assign vblank     = (vc_q >= V_ACT);
    assign frame_done = (hc_q == HT_LAST) && (vc_q == VT_LAST);

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: full-size timing instance (RD_LAT=1) plus a shrunken-raster
// instance (RD_LAT=3) that covers whole frames; both scored against a cycle-index model.
`timescale 1ns/1ps

module tb_vga_fb_scanout;

    typedef struct {
        logic [9:0]  hc;
        logic [9:0]  vc;
        logic        vblank;
        logic        frame_done;
        logic        rd_en;
        logic [16:0] rd_addr;
        logic        hsync;
        logic        vsync;
        logic [11:0] rgb;
    } exp_t;

    localparam int TIME_LIMIT = 400000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit finished = 1'b0;
    bit done [2] = '{1'b0, 1'b0};

    task automatic summary_and_finish();
        if (!finished) begin
            finished = 1'b1;
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    endtask

    task automatic check(input int inst, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL dut%0d %s actual=%0h expected=%0h t=%0t", inst, what, act, exp, $time);
            if (failures >= 40) summary_and_finish();
        end
    endtask

    // RGB332 -> RGB444: replicate the top bit of R and G, double up B.
    function automatic logic [11:0] expand(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    // Screen pixel (h,v) reads buffer column 239-v/2 of row h/2 in a 240-wide buffer.
    function automatic int fb_addr(input int h, input int v);
        return (h / 2) * 240 + (239 - v / 2);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int HA  = (g == 0) ? 640 : 16;
        localparam int HF  = (g == 0) ? 16  : 2;
        localparam int HS  = (g == 0) ? 96  : 4;
        localparam int HB  = (g == 0) ? 48  : 2;
        localparam int VA  = (g == 0) ? 480 : 12;
        localparam int VF  = (g == 0) ? 10  : 2;
        localparam int VS  = (g == 0) ? 2   : 2;
        localparam int VB  = (g == 0) ? 33  : 3;
        localparam int LAT = (g == 0) ? 1   : 3;
        localparam int HT  = HA + HF + HS + HB;
        localparam int VT  = VA + VF + VS + VB;
        localparam int L   = LAT + 2;
        localparam int RUN1 = (g == 0) ? (3 * HT + 300) : (2 * HT * VT + 5 * HT + 7);
        localparam int RUN2 = (g == 0) ? 24000 : (3 * HT * VT + 10);

        logic        rst;
        logic        rd_en;
        logic [16:0] rd_addr;
        logic [7:0]  rd_data;
        logic        hsync;
        logic        vsync;
        logic [3:0]  red;
        logic [3:0]  green;
        logic [3:0]  blue;
        logic [9:0]  hc;
        logic [9:0]  vc;
        logic        vblank;
        logic        frame_done;

        vga_fb_scanout #(
            .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
            .FB_W(240), .FB_H(320), .ADDR_W(17), .RD_LAT(LAT)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .rd_en      (rd_en),
            .rd_addr    (rd_addr),
            .rd_data    (rd_data),
            .hsync      (hsync),
            .vsync      (vsync),
            .red        (red),
            .green      (green),
            .blue       (blue),
            .hc         (hc),
            .vc         (vc),
            .vblank     (vblank),
            .frame_done (frame_done)
        );

        // Frame-buffer RAM with LAT clocks of read latency; idle data is all ones.
        logic [7:0]     mem [76800];
        logic [LAT-1:0] rv_q = '0;
        logic [7:0]     rdq [LAT];

        always @(posedge clk) begin
            rv_q   <= LAT'({rv_q, rd_en});
            rdq[0] <= mem[rd_addr];
            for (int i = 1; i < LAT; i++) rdq[i] <= rdq[i-1];
        end
        assign rd_data = rv_q[LAT-1] ? rdq[LAT-1] : 8'hFF;

        exp_t        sb [$];
        int          n;
        logic [16:0] last_addr;
        bit          running = 1'b0;

        exp_t e;
        int   h, v, hp, vp, m, hm, vm;

        // Model: cycle n after release shows counters for n, request for n-1, pins for n-L.
        always @(negedge clk) begin
            if (running) begin
                h = n % HT;
                v = (n / HT) % VT;
                e.hc         = 10'(h);
                e.vc         = 10'(v);
                e.vblank     = (v >= VA);
                e.frame_done = (h == HT - 1) && (v == VT - 1);
                e.rd_en      = 1'b0;
                if (n >= 1) begin
                    hp = (n - 1) % HT;
                    vp = ((n - 1) / HT) % VT;
                    if (hp < HA && vp < VA) begin
                        e.rd_en   = 1'b1;
                        last_addr = 17'(fb_addr(hp, vp));
                    end
                end
                e.rd_addr = last_addr;
                m = n - L;
                e.hsync = 1'b1;
                e.vsync = 1'b1;
                e.rgb   = '0;
                if (m >= 0) begin
                    hm = m % HT;
                    vm = (m / HT) % VT;
                    e.hsync = !(hm >= HA + HF && hm < HA + HF + HS);
                    e.vsync = !(vm >= VA + VF && vm < VA + VF + VS);
                    if (hm < HA && vm < VA) e.rgb = expand(mem[fb_addr(hm, vm)]);
                end
                sb.push_back(e);
                n++;
            end
        end

        // Monitor: pops one expectation per sampled cycle and compares every output.
        exp_t got;
        always @(negedge clk) begin
            if (running) begin
                #1;
                if (sb.size() == 0) begin
                    check(g, "scoreboard_empty", 32'(sb.size()), 32'd1);
                end else begin
                    got = sb.pop_front();
                    check(g, "hc", 32'(hc), 32'(got.hc));
                    check(g, "vc", 32'(vc), 32'(got.vc));
                    check(g, "vblank", 32'(vblank), 32'(got.vblank));
                    check(g, "frame_done", 32'(frame_done), 32'(got.frame_done));
                    check(g, "rd_en", 32'(rd_en), 32'(got.rd_en));
                    check(g, "rd_addr", 32'(rd_addr), 32'(got.rd_addr));
                    check(g, "hsync", 32'(hsync), 32'(got.hsync));
                    check(g, "vsync", 32'(vsync), 32'(got.vsync));
                    check(g, "rgb", 32'({red, green, blue}), 32'(got.rgb));
                end
            end
        end

        task automatic reset_checks(input string tag);
            check(g, {tag, "_hc"}, 32'(hc), 32'd0);
            check(g, {tag, "_vc"}, 32'(vc), 32'd0);
            check(g, {tag, "_rd_en"}, 32'(rd_en), 32'd0);
            check(g, {tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
            check(g, {tag, "_hsync"}, 32'(hsync), 32'd1);
            check(g, {tag, "_vsync"}, 32'(vsync), 32'd1);
            check(g, {tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
            check(g, {tag, "_vblank"}, 32'(vblank), 32'd0);
            check(g, {tag, "_frame_done"}, 32'(frame_done), 32'd0);
        endtask

        initial begin
            for (int i = 0; i < 76800; i++) mem[i] = 8'($urandom);
            mem[239] = 8'hE3;
            mem[479] = 8'h49;
            rst       = 1'b0;
            n         = 0;
            last_addr = '0;
            repeat (3) @(posedge clk);
            #1;
            reset_checks("reset");
            rst     = 1'b1;
            running = 1'b1;

            // Assert reset mid-active so the pipeline holds live colour when it is cut.
            repeat (RUN1) @(posedge clk);
            #3;
            running = 1'b0;
            rst     = 1'b0;
            #1;
            reset_checks("midreset");

            repeat (3) @(posedge clk);
            #1;
            sb.delete();
            n         = 0;
            last_addr = '0;
            rst       = 1'b1;
            running   = 1'b1;

            repeat (RUN2) @(posedge clk);
            @(negedge clk);
            #2;
            running = 1'b0;
            done[g] = 1'b1;
        end
    end

    initial begin
        fork
            wait (done[0] && done[1]);
            #(TIME_LIMIT);
        join_any
        disable fork;
        check(-1, "run_complete", 32'(done[0] && done[1]), 32'd1);
        summary_and_finish();
    end

endmodule
